// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and helpers for the PC sequencer and its return-address stack.
package cpu_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2
   } pc_state_t;

   localparam int INSN_BYTES = 4;
   localparam int INSN_SHIFT = $clog2(INSN_BYTES);

   // Sign-extends an ofs_w-bit word offset to 64 bits and scales it to a byte offset.
   function automatic logic [63:0] sext_offset(input logic [63:0] ofs, input int unsigned ofs_w);
      logic [63:0] r;
      r = ofs << (64 - ofs_w);
      r = $unsigned($signed(r) >>> (64 - ofs_w));
      return r << INSN_SHIFT;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode <-> PC sequencer bundle. Decode is the master; the sequencer is the slave.
interface pc_sequencer_if #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 24
);

   // Level-qualified, no ready: br_* and ret_valid are sampled on the rising edge only
   // while state is RUN; outside RUN decode must hold them low. Outputs are registered.
   logic                stall;
   logic                br_valid;
   logic                br_link;
   logic                br_taken;
   logic [ADDR_W-1:0]   br_pc;
   logic [OFFSET_W-1:0] br_offset;
   logic                ret_valid;

   logic [ADDR_W-1:0]   pc;
   logic                fetch_valid;
   logic                flush;
   logic                link_we;
   logic [ADDR_W-1:0]   link_data;
   logic                ras_err;
   cpu_pkg::pc_state_t  state;

   modport master (
      output stall, br_valid, br_link, br_taken, br_pc, br_offset, ret_valid,
      input  pc, fetch_valid, flush, link_we, link_data, ras_err, state
   );

   modport slave (
      input  stall, br_valid, br_link, br_taken, br_pc, br_offset, ret_valid,
      output pc, fetch_valid, flush, link_we, link_data, ras_err, state
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full,
   output logic         err
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW:0]   cnt;
   logic          pop_ok;

   assign empty  = (cnt == '0);
   assign full   = (cnt == (PW+1)'(DEPTH));
   assign top    = mem[wp - PW'(1)];
   assign pop_ok = pop && !push && !empty;
   assign err    = (push && full) || (pop && !push && empty);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= push_data;
      end
   end

   // The write pointer wraps freely; when full it already sits on the oldest entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         cnt <= '0;
      end else if (push) begin
         wp <= wp + PW'(1);
         if (!full) begin
            cnt <= cnt + (PW+1)'(1);
         end
      end else if (pop_ok) begin
         wp  <= wp - PW'(1);
         cnt <= cnt - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch-stage PC sequencer: sequential, branch, branch-with-link and return redirects.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                OFFSET_W  = 24,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                PIPE_OFS  = 8,
   parameter int                BUBBLES   = 1,
   parameter int                RAS_DEPTH = 4
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);

   pc_state_t         state, state_nx;
   logic [2:0]        bub_cnt, bub_cnt_nx;
   logic [ADDR_W-1:0] pc_r, pc_nx;
   logic              flush_r, flush_nx;
   logic              link_we_r, link_we_nx;
   logic [ADDR_W-1:0] link_data_r, link_data_nx;
   logic              ras_err_r, ras_err_nx;

   logic              take_br;
   logic              ret_hit;
   logic              ras_err_c;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] link_addr;

   assign take_br   = bus.br_valid && bus.br_taken;
   assign target    = bus.br_pc + ADDR_W'(sext_offset(64'(bus.br_offset), OFFSET_W))
                      + ADDR_W'(PIPE_OFS);
   assign link_addr = bus.br_pc + ADDR_W'(INSN_BYTES);

`ifdef PC_SEQ_RAS_EN
   logic ras_push, ras_pop, ras_empty, ras_full_unused;

   // A resolving branch, taken or not, shadows a return in the same cycle.
   assign ras_push = (state == RUN) && take_br && bus.br_link;
   assign ras_pop  = (state == RUN) && bus.ret_valid && !bus.br_valid;
   assign ret_hit  = ras_pop && !ras_empty;

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (link_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full_unused),
      .err       (ras_err_c)
   );
`else
   logic unused_ret;

   assign unused_ret = ^{bus.ret_valid, 1'(RAS_DEPTH)};
   assign ret_hit    = 1'b0;
   assign ras_top    = '0;
   assign ras_err_c  = 1'b0;
`endif

   always_comb begin
      state_nx     = state;
      bub_cnt_nx   = bub_cnt;
      pc_nx        = pc_r;
      flush_nx     = 1'b0;
      link_we_nx   = 1'b0;
      link_data_nx = link_data_r;
      ras_err_nx   = 1'b0;
      case (state)
         BOOT: state_nx = RUN;
         RUN: begin
            ras_err_nx = ras_err_c;
            if (take_br) begin
               pc_nx      = target;
               flush_nx   = 1'b1;
               state_nx   = BUBBLE;
               bub_cnt_nx = 3'(BUBBLES - 1);
               if (bus.br_link) begin
                  link_we_nx   = 1'b1;
                  link_data_nx = link_addr;
               end
            end else if (ret_hit) begin
               pc_nx      = ras_top;
               flush_nx   = 1'b1;
               state_nx   = BUBBLE;
               bub_cnt_nx = 3'(BUBBLES - 1);
            end else if (!bus.stall) begin
               pc_nx = pc_r + ADDR_W'(INSN_BYTES);
            end
         end
         BUBBLE: begin
            if (bub_cnt == '0) begin
               state_nx = RUN;
            end else begin
               bub_cnt_nx = bub_cnt - 3'd1;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         bub_cnt     <= '0;
         pc_r        <= RESET_PC;
         flush_r     <= 1'b0;
         link_we_r   <= 1'b0;
         link_data_r <= '0;
         ras_err_r   <= 1'b0;
      end else begin
         state       <= state_nx;
         bub_cnt     <= bub_cnt_nx;
         pc_r        <= pc_nx;
         flush_r     <= flush_nx;
         link_we_r   <= link_we_nx;
         link_data_r <= link_data_nx;
         ras_err_r   <= ras_err_nx;
      end
   end

   assign bus.pc          = pc_r;
   assign bus.fetch_valid = (state == RUN);
   assign bus.flush       = flush_r;
   assign bus.link_we     = link_we_r;
   assign bus.link_data   = link_data_r;
   assign bus.ras_err     = ras_err_r;
   assign bus.state       = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; exercises the RAS scenarios when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

   localparam int          ADDR_W    = 32;
   localparam int          OFFSET_W  = 24;
   localparam int          BUBBLES   = 2;
   localparam int          RAS_DEPTH = 2;
   localparam logic [31:0] RESET_PC  = 32'h100;
`ifdef PC_SEQ_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic        fv;
      logic        fl;
      logic        lwe;
      logic [31:0] ld;
      logic        err;
   } obs_t;
   localparam int OBS_W = $bits(obs_t);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [OBS_W-1:0] exp_q[$];
   logic [OBS_W-1:0] obs_q[$];
   logic [31:0]      ld_exp = '0;
   int               n_chk = 0;
   int               n_pass = 0;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) bus ();

   pc_sequencer #(
      .ADDR_W    (ADDR_W),
      .OFFSET_W  (OFFSET_W),
      .RESET_PC  (RESET_PC),
      .PIPE_OFS  (8),
      .BUBBLES   (BUBBLES),
      .RAS_DEPTH (RAS_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && bus.state != cpu_pkg::RUN)
         assert (!(bus.br_valid || bus.ret_valid))
            else $error("decode presented branch/ret outside RUN");
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   function automatic obs_t pk(input logic [31:0] pc, input logic fv, input logic fl,
                               input logic lwe, input logic [31:0] ld, input logic err);
      pk = '{pc: pc, fv: fv, fl: fl, lwe: lwe, ld: ld, err: err};
   endfunction

   function automatic string fmt(input obs_t v);
      fmt = $sformatf("pc=%h fv=%b flush=%b link_we=%b link_data=%h ras_err=%b",
                      v.pc, v.fv, v.fl, v.lwe, v.ld, v.err);
   endfunction

   task automatic idle();
      bus.stall     = 1'b0;
      bus.br_valid  = 1'b0;
      bus.br_link   = 1'b0;
      bus.br_taken  = 1'b0;
      bus.br_pc     = '0;
      bus.br_offset = '0;
      bus.ret_valid = 1'b0;
   endtask

   task automatic branch(input logic taken, input logic link, input logic [31:0] bpc,
                         input logic [23:0] ofs);
      bus.br_valid  = 1'b1;
      bus.br_taken  = taken;
      bus.br_link   = link;
      bus.br_pc     = bpc;
      bus.br_offset = ofs;
   endtask

   // Queue the expectation for the next edge, advance, capture what the DUT shows.
   task automatic cycle(input obs_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      obs_q.push_back({bus.pc, bus.fetch_valid, bus.flush, bus.link_we, bus.link_data, bus.ras_err});
   endtask

   // Remaining bubble cycles after the flush cycle, then the first real fetch of t.
   task automatic bubble_run(input logic [31:0] t);
      for (int i = 1; i < BUBBLES; i++) cycle(pk(t, 0, 0, 0, ld_exp, 0));
      cycle(pk(t, 1, 0, 0, ld_exp, 0));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      obs_t e, o;
      int k = 0;
      idle();
      reset = 1'b1;
      ld_exp = '0;
      cycle(pk(RESET_PC, 0, 0, 0, 0, 0));
      cycle(pk(RESET_PC, 0, 0, 0, 0, 0));
      reset = 1'b0;
      cycle(pk(RESET_PC, 1, 0, 0, 0, 0));
      cycle(pk(RESET_PC + 4, 1, 0, 0, 0, 0));
      cycle(pk(RESET_PC + 8, 1, 0, 0, 0, 0));
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL reset[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_branch();
      obs_t e, o;
      int k = 0;
      branch(1, 0, 32'h200, 24'hFFFFFE);
      cycle(pk(32'h200, 0, 1, 0, ld_exp, 0));
      idle();
      bubble_run(32'h200);
      cycle(pk(32'h204, 1, 0, 0, ld_exp, 0));
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL branch[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_link();
      obs_t e, o;
      int k = 0;
      branch(1, 1, 32'h40, 24'h10);
      ld_exp = 32'h44;
      cycle(pk(32'h88, 0, 1, 1, ld_exp, 0));
      idle();
      bubble_run(32'h88);
      branch(0, 1, 32'h40, 24'h10);
      cycle(pk(32'h8C, 1, 0, 0, ld_exp, 0));
      idle();
      cycle(pk(32'h90, 1, 0, 0, ld_exp, 0));
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL link[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_stall();
      obs_t e, o;
      int k = 0;
      branch(1, 0, 32'h8, 24'h0);
      cycle(pk(32'h10, 0, 1, 0, ld_exp, 0));
      idle();
      bubble_run(32'h10);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) cycle(pk(32'h10, 1, 0, 0, ld_exp, 0));
      branch(0, 0, 32'h10, 24'h1);
      cycle(pk(32'h10, 1, 0, 0, ld_exp, 0));
      branch(1, 1, 32'h10, 24'h1);
      ld_exp = 32'h14;
      cycle(pk(32'h1C, 0, 1, 1, ld_exp, 0));
      idle();
      bubble_run(32'h1C);
      cycle(pk(32'h20, 1, 0, 0, ld_exp, 0));
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL stall[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_wrap_reset();
      obs_t e, o;
      int k = 0;
      branch(1, 0, 32'h10, 24'h800000);
      cycle(pk(32'hFE000018, 0, 1, 0, ld_exp, 0));
      idle();
      bubble_run(32'hFE000018);
      branch(1, 0, 32'hFFFFFFF8, 24'h0);
      cycle(pk(32'h0, 0, 1, 0, ld_exp, 0));
      idle();
      reset = 1'b1;
      ld_exp = '0;
      cycle(pk(RESET_PC, 0, 0, 0, 0, 0));
      reset = 1'b0;
      cycle(pk(RESET_PC, 1, 0, 0, 0, 0));
      cycle(pk(RESET_PC + 4, 1, 0, 0, 0, 0));
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL wrap_reset[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_ret_empty();
      obs_t e, o;
      int k = 0;
      bus.ret_valid = 1'b1;
      cycle(pk(32'h108, 1, 0, 0, ld_exp, RAS_ON));
      idle();
      cycle(pk(32'h10C, 1, 0, 0, ld_exp, 0));
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL ret_empty[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask

   task automatic test_random_seq();
      obs_t e, o;
      int k = 0;
      logic [31:0] p = 32'h10C;
      for (int i = 0; i < 24; i++) begin
         idle();
         bus.stall = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1)
            branch(0, 1'($urandom_range(0, 1)), $urandom, 24'($urandom));
         if (!bus.stall) p = p + 4;
         cycle(pk(p, 1, 0, 0, ld_exp, 0));
      end
      idle();
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL random_seq[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask

`ifdef PC_SEQ_RAS_EN
   task automatic test_ras();
      obs_t e, o;
      int k = 0;
      logic [31:0] base;
      idle();
      reset = 1'b1;
      ld_exp = '0;
      cycle(pk(RESET_PC, 0, 0, 0, 0, 0));
      reset = 1'b0;
      cycle(pk(RESET_PC, 1, 0, 0, 0, 0));
      for (int n = 1; n <= 3; n++) begin
         base = 32'(n) << 8;
         branch(1, 1, base, 24'h0);
         ld_exp = base + 4;
         cycle(pk(base + 8, 0, 1, 1, ld_exp, n == 3));
         idle();
         bubble_run(base + 8);
      end
      branch(0, 0, 32'h300, 24'h0);
      bus.ret_valid = 1'b1;
      cycle(pk(32'h30C, 1, 0, 0, ld_exp, 0));
      idle();
      bus.ret_valid = 1'b1;
      cycle(pk(32'h304, 0, 1, 0, ld_exp, 0));
      idle();
      bubble_run(32'h304);
      bus.ret_valid = 1'b1;
      cycle(pk(32'h204, 0, 1, 0, ld_exp, 0));
      idle();
      bubble_run(32'h204);
      bus.ret_valid = 1'b1;
      cycle(pk(32'h208, 1, 0, 0, ld_exp, 1));
      idle();
      cycle(pk(32'h20C, 1, 0, 0, ld_exp, 0));
      while (exp_q.size() != 0) begin
         e = obs_t'(exp_q.pop_front()); o = obs_t'(obs_q.pop_front()); n_chk++;
         if (o !== e) $display("FAIL ras[%0d]: got %s, required %s", k, fmt(o), fmt(e));
         else n_pass++;
         k++;
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      idle();
      test_reset();
      test_branch();
      test_link();
      test_stall();
      test_wrap_reset();
      test_ret_empty();
      test_random_seq();
`ifdef PC_SEQ_RAS_EN
      test_ras();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
